// File: rtl/xspi_scoreboard.sv
// rtl/xspi_scoreboard.sv - shadow-table scoreboard checking xSPI read completions against prior writes
module xspi_scoreboard #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              done,
    input  logic              op_is_rd,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              ready,
    input  logic              clear,
    output logic              check_valid,
    output logic              check_pass,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  ready_events,
    output logic              err,
    output logic [ADDR_W-1:0] last_fail_addr,
    output logic [DATA_W-1:0] last_exp,
    output logic [DATA_W-1:0] last_got
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]  tbl_valid;
    logic [ADDR_W-1:0] tbl_addr [DEPTH];
    logic [DATA_W-1:0] tbl_data [DEPTH];
    logic [IDX_W-1:0]  evict_ptr;
    logic              ready_q;

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] hit_data;
    logic              do_wr;
    logic              do_rd;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Lookup and allocation: descending scan so the lowest matching/free index wins
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tbl_valid[i] && tbl_addr[i] == op_addr) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!tbl_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        hit_data = tbl_data[hit_idx];
        wr_idx   = hit ? hit_idx : (free_found ? free_idx : evict_ptr);
        do_wr    = done && !op_is_rd && !clear;
        do_rd    = done && op_is_rd && !clear;
    end

    // Valid bits and eviction pointer; the pointer only moves when a miss hits a full table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_valid <= '0;
            evict_ptr <= '0;
        end else if (clear) begin
            tbl_valid <= '0;
            evict_ptr <= '0;
        end else if (do_wr) begin
            tbl_valid[wr_idx] <= 1'b1;
            if (!hit && !free_found) begin
                evict_ptr <= evict_ptr + IDX_W'(1);
            end
        end
    end

    // Table payload; contents are meaningless while the valid bit is low, so no reset
    always_ff @(posedge clk) begin
        if (do_wr) begin
            tbl_addr[wr_idx] <= op_addr;
            tbl_data[wr_idx] <= wr_data;
        end
    end

    // Counters, compare result, sticky error and failure context
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            check_valid    <= 1'b0;
            check_pass     <= 1'b0;
            wr_count       <= '0;
            rd_count       <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            miss_count     <= '0;
            ready_events   <= '0;
            err            <= 1'b0;
            last_fail_addr <= '0;
            last_exp       <= '0;
            last_got       <= '0;
            ready_q        <= 1'b0;
        end else if (clear) begin
            check_valid    <= 1'b0;
            check_pass     <= 1'b0;
            wr_count       <= '0;
            rd_count       <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            miss_count     <= '0;
            ready_events   <= '0;
            err            <= 1'b0;
            last_fail_addr <= '0;
            last_exp       <= '0;
            last_got       <= '0;
            ready_q        <= ready;
        end else begin
            ready_q     <= ready;
            check_valid <= 1'b0;
            check_pass  <= 1'b0;
            if (ready && !ready_q) begin
                ready_events <= sat_inc(ready_events);
            end
            if (do_wr) begin
                wr_count <= sat_inc(wr_count);
            end
            if (do_rd) begin
                rd_count <= sat_inc(rd_count);
                if (!hit) begin
                    miss_count <= sat_inc(miss_count);
                end else if (rd_data == hit_data) begin
                    check_valid <= 1'b1;
                    check_pass  <= 1'b1;
                    pass_count  <= sat_inc(pass_count);
                end else begin
                    check_valid    <= 1'b1;
                    fail_count     <= sat_inc(fail_count);
                    err            <= 1'b1;
                    last_fail_addr <= op_addr;
                    last_exp       <= hit_data;
                    last_got       <= rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_xspi_scoreboard.sv
// tb/tb_xspi_scoreboard.sv - directed scoreboard bench for xspi_scoreboard
module tb_xspi_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        done;
    logic        op_is_rd;
    logic [31:0] op_addr;
    logic [63:0] wr_data;
    logic [63:0] rd_data;
    logic        ready;
    logic        clear;

    logic        a_cv, a_cp, a_err;
    logic [15:0] a_wr, a_rd, a_pass, a_fail, a_miss, a_rdy;
    logic [31:0] a_lfa;
    logic [63:0] a_lexp, a_lgot;

    logic        b_cv, b_cp, b_err;
    logic [1:0]  b_wr, b_rd, b_pass, b_fail, b_miss, b_rdy;
    logic [31:0] b_lfa;
    logic [63:0] b_lexp, b_lgot;

    int n_checks = 0;
    int n_fail   = 0;
    int e_wr, e_rd, e_pass, e_fail, e_miss, e_rdy;
    logic [1:0] exp_q[$];

    localparam logic [63:0] D1 = 64'h1122334455667788;
    localparam logic [63:0] DB = 64'hDEADBEEF00000000;

    always #5 clk = ~clk;

    xspi_scoreboard #(.DATA_W(64), .ADDR_W(32), .DEPTH(8), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .done(done), .op_is_rd(op_is_rd), .op_addr(op_addr),
        .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .clear(clear),
        .check_valid(a_cv), .check_pass(a_cp), .wr_count(a_wr), .rd_count(a_rd),
        .pass_count(a_pass), .fail_count(a_fail), .miss_count(a_miss), .ready_events(a_rdy),
        .err(a_err), .last_fail_addr(a_lfa), .last_exp(a_lexp), .last_got(a_lgot)
    );

    xspi_scoreboard #(.DATA_W(64), .ADDR_W(32), .DEPTH(8), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .done(done), .op_is_rd(op_is_rd), .op_addr(op_addr),
        .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .clear(clear),
        .check_valid(b_cv), .check_pass(b_cp), .wr_count(b_wr), .rd_count(b_rd),
        .pass_count(b_pass), .fail_count(b_fail), .miss_count(b_miss), .ready_events(b_rdy),
        .err(b_err), .last_fail_addr(b_lfa), .last_exp(b_lexp), .last_got(b_lgot)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic chk_counters(input string tag);
        chk({tag, " a.wr"},   64'(a_wr),   64'(e_wr));
        chk({tag, " a.rd"},   64'(a_rd),   64'(e_rd));
        chk({tag, " a.pass"}, 64'(a_pass), 64'(e_pass));
        chk({tag, " a.fail"}, 64'(a_fail), 64'(e_fail));
        chk({tag, " a.miss"}, 64'(a_miss), 64'(e_miss));
        chk({tag, " a.rdy"},  64'(a_rdy),  64'(e_rdy));
        chk({tag, " b.wr"},   64'(b_wr),   64'(sat3(e_wr)));
        chk({tag, " b.rd"},   64'(b_rd),   64'(sat3(e_rd)));
        chk({tag, " b.pass"}, 64'(b_pass), 64'(sat3(e_pass)));
        chk({tag, " b.fail"}, 64'(b_fail), 64'(sat3(e_fail)));
        chk({tag, " b.miss"}, 64'(b_miss), 64'(sat3(e_miss)));
        chk({tag, " b.rdy"},  64'(b_rdy),  64'(sat3(e_rdy)));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " a.cv"},  64'(a_cv), 64'd0);
        chk({tag, " a.cp"},  64'(a_cp), 64'd0);
        chk({tag, " a.err"}, 64'(a_err), 64'd0);
        chk({tag, " a.lfa"}, 64'(a_lfa), 64'd0);
        chk({tag, " a.lexp"}, a_lexp, 64'd0);
        chk({tag, " a.lgot"}, a_lgot, 64'd0);
        chk({tag, " b.cv"},  64'(b_cv), 64'd0);
        chk({tag, " b.err"}, 64'(b_err), 64'd0);
        chk_counters(tag);
    endtask

    // Drive one completion at a negedge, then compare the registered result one cycle later
    task automatic op(input string tag, input logic rd, input logic [31:0] a, input logic [63:0] d,
                      input logic ecv, input logic ecp);
        logic [1:0] e;
        done     = 1'b1;
        op_is_rd = rd;
        op_addr  = a;
        wr_data  = rd ? 64'd0 : d;
        rd_data  = rd ? d : 64'd0;
        if (!rd) e_wr++;
        else begin
            e_rd++;
            if (!ecv) e_miss++;
            else if (ecp) e_pass++;
            else e_fail++;
        end
        exp_q.push_back({ecv, ecp});
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, " a.cv"}, 64'(a_cv), 64'(e[1]));
        chk({tag, " b.cv"}, 64'(b_cv), 64'(e[1]));
        if (e[1]) chk({tag, " a.cp"}, 64'(a_cp), 64'(e[0]));
    endtask

    task automatic idle();
        done = 1'b0;
        @(negedge clk);
        chk("idle a.cv", 64'(a_cv), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; done = 1'b0; op_is_rd = 1'b0; op_addr = '0;
        wr_data = '0; rd_data = '0; ready = 1'b0; clear = 1'b0;
        e_wr = 0; e_rd = 0; e_pass = 0; e_fail = 0; e_miss = 0; e_rdy = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");

        // Basic write then matching read
        op("t1 wr", 1'b0, 32'h10, D1, 1'b0, 1'b0);
        op("t1 rd", 1'b1, 32'h10, D1, 1'b1, 1'b1);
        idle();
        chk_counters("t1");
        chk("t1 err", 64'(a_err), 64'd0);

        // Mismatching read sets err and failure context; a later pass keeps err
        op("t2 wr", 1'b0, 32'h10, D1, 1'b0, 1'b0);
        op("t2 rd", 1'b1, 32'h10, DB, 1'b1, 1'b0);
        chk("t2 err", 64'(a_err), 64'd1);
        chk("t2 lfa", 64'(a_lfa), 64'h10);
        chk("t2 lexp", a_lexp, D1);
        chk("t2 lgot", a_lgot, DB);
        op("t2 rd2", 1'b1, 32'h10, D1, 1'b1, 1'b1);
        chk("t2 err sticky", 64'(a_err), 64'd1);
        chk("t2 lgot held", a_lgot, DB);

        // Read of an address never written
        op("t3 rd", 1'b1, 32'h20, 64'd0, 1'b0, 1'b0);
        idle();
        chk_counters("t3");

        // Clear coinciding with a done discards the event
        clear = 1'b1; done = 1'b1; op_is_rd = 1'b1; op_addr = 32'h10; rd_data = D1;
        @(negedge clk);
        clear = 1'b0; done = 1'b0;
        e_wr = 0; e_rd = 0; e_pass = 0; e_fail = 0; e_miss = 0;
        chk_all_zero("clear");
        op("clr rd", 1'b1, 32'h10, D1, 1'b0, 1'b0);

        // Fill past DEPTH: the 9th write evicts entry 0
        for (int i = 0; i <= 8; i++) op("fill wr", 1'b0, 32'(i), 64'(i + 1), 1'b0, 1'b0);
        op("evict rd0", 1'b1, 32'd0, 64'd1, 1'b0, 1'b0);
        op("evict rd8", 1'b1, 32'd8, 64'd9, 1'b1, 1'b1);
        op("rew wr3", 1'b0, 32'd3, 64'h55, 1'b0, 1'b0);
        op("rew rd3", 1'b1, 32'd3, 64'h55, 1'b1, 1'b1);
        op("evict wr99", 1'b0, 32'h99, 64'h77, 1'b0, 1'b0);
        op("evict rd1", 1'b1, 32'd1, 64'd2, 1'b0, 1'b0);
        op("evict rd2", 1'b1, 32'd2, 64'd3, 1'b1, 1'b1);
        idle();
        chk_counters("fill");

        // Back-to-back write then read of the same address
        op("b2b wr", 1'b0, 32'h40, 64'hAA, 1'b0, 1'b0);
        op("b2b rd", 1'b1, 32'h40, 64'hAA, 1'b1, 1'b1);
        idle();
        chk_counters("b2b");

        // Ready rising edges
        for (int i = 0; i < 3; i++) begin
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
            @(negedge clk);
            e_rdy++;
        end
        chk_counters("ready");

        // Asynchronous reset right after a read hit is registered
        done = 1'b1; op_is_rd = 1'b1; op_addr = 32'h40; rd_data = 64'hAA;
        @(posedge clk);
        #1;
        chk("arst pre a.cv", 64'(a_cv), 64'd1);
        done = 1'b0;
        ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        e_wr = 0; e_rd = 0; e_pass = 0; e_fail = 0; e_miss = 0; e_rdy = 0;
        chk_all_zero("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e_rdy = 1;
        chk_counters("ready after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/xspi_scoreboard.md
# xspi_scoreboard

Synthesizable, parametrised scoreboard for the xSPI 8S controller. It sits beside the controller and snoops the completion handshake. It keeps a small shadow table of written addresses and data, and checks every completed read against the expected value. It exposes pass, fail, miss and write counters, the last failure context, and a sticky error flag, so self-checking runs on silicon or FPGA without simulator `$display`.

## Interface
- DATA_W, 64, data word width (wr_data, rd_data, last_exp, last_got).
- ADDR_W, 32, operation address width.
- DEPTH, 8, shadow table entries; power of two, ≥2.
- CNT_W, 16, width of every event counter.
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- done  in  1  one-cycle operation-complete pulse from controller.
- op_is_rd  in  1  qualifies done: 1 = read, 0 = write.
- op_addr  in  ADDR_W  address of completed operation, valid with done.
- wr_data  in  DATA_W  written data, valid with done & !op_is_rd.
- rd_data  in  DATA_W  returned data, valid with done & op_is_rd.
- ready  in  1  controller/slave ready level.
- clear  in  1  synchronous clear of table, counters and flags.
- check_valid  out  1  one-cycle pulse: a read hit was compared.
- check_pass  out  1  result of that compare; valid only with check_valid.
- wr_count, rd_count, pass_count, fail_count, miss_count, ready_events  out  CNT_W each  event counters.
- err  out  1  sticky; set on the first fail.
- last_fail_addr  out  ADDR_W; last_exp, last_got  out  DATA_W  context of the most recent fail.

## Operation
- Reset and clear: all outputs 0, all table valid bits 0, eviction pointer 0. Priority is rst_n > clear > done/ready. An event in a clear cycle is discarded.
- Table entry: {valid, addr, data}. Lookup matches valid entries with equal addr. Uniqueness is guaranteed by the write policy, and the lowest index wins.
- Write (done & !op_is_rd):
  - Hit: overwrite data.
  - No hit: allocate the lowest-index invalid entry.
  - Table full: replace the entry at the eviction pointer, then increment the pointer mod DEPTH.
  - wr_count increments.
- Read (done & op_is_rd): rd_count increments.
  - Hit, rd_data == stored data: check_valid=1, check_pass=1, pass_count increments.
  - Hit, mismatch: check_valid=1, check_pass=0, fail_count increments, err=1. last_fail_addr/last_exp/last_got load op_addr, stored data and rd_data.
  - Miss: no check_valid, miss_count increments.
- ready_events increments on each 0→1 transition of ready. ready is sampled each cycle, and the previous-value register resets to 0, so ready high out of reset counts as one event.
- All counters saturate at 2^CNT_W−1; they never wrap.
- The last_* fields hold their values until the next fail, clear, or reset. err clears only on clear or reset.

## Timing
- done sampled at edge N. Table, counters, check_valid/check_pass, err and last_* update at edge N (registered), so they are visible in cycle N+1. There is no further latency.
- check_valid is high for exactly one cycle per read hit.
- done may assert every cycle. A write at N followed by a read of the same address at N+1 compares against the data written at N.
- A write and a read never occur in the same cycle (single done). op_is_rd, op_addr and data are ignored when done=0.
- Async reset mid-operation: the pending compare is lost and outputs go to 0 immediately on rst_n fall.

## Test plan
- Write A=0x10 D=0x1122334455667788, then read A=0x10 with the same data:
  - wr_count=1, rd_count=1, pass_count=1.
  - check_valid and check_pass high one cycle after the read done.
  - err=0.
- Write 0x10, then read 0x10 returning 0xDEADBEEF00000000:
  - fail_count=1, err=1, last_fail_addr=0x10.
  - last_exp=0x1122334455667788, last_got=0xDEADBEEF00000000.
  - A following passing read keeps err=1.
- Read 0x20 never written: miss_count=1, check_valid stays 0.
- DEPTH=8:
  - Write addresses 0..8 with data=addr+1; the 9th write evicts entry 0.
  - Read 0 → miss_count=1. Read 8 → pass. Rewrite 3 with 0x55, read 3 with 0x55 → pass, with no new eviction.
- Back-to-back: write 0x40=0xAA at N, read 0x40 = 0xAA at N+1 → pass. Assert clear together with a done → that event is not counted, and all counters are 0 the next cycle.
- Saturation and ready, with CNT_W=2:
  - 5 passing reads → pass_count=3.
  - Toggle ready 0→1 three times → ready_events=3.
  - Drop rst_n mid-sequence → all outputs 0 asynchronously.
